// File: rtl/instr_stream_gen.sv
// instr_stream_gen
//   Pseudo-random MIPS instruction word source. Draws one of the 55 supported
//   instructions per word from a 32-bit Galois LFSR and offers it over a
//   valid/ready handshake. It is the stimulus for the fetch-side legality checker.
//
// Parameters
//   SEED   initial LFSR state loaded on start (0 is replaced by 1)
//   LEN_W  width of length / emitted
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   begin a run (only looked at in IDLE)
//   length    in   words to emit, captured with start
//   valid     out  instr holds a word to transfer
//   ready     in   consumer accepts the word this cycle
//   instr     out  instruction word
//   op_index  out  index 0..54 of the instruction (63 for an injected word)
//   illegal   out  current word is a deliberately unsupported encoding
//   emitted   out  words transferred in the current run
//   done      out  one-cycle pulse when a run ends
//
// Build option
//   INSTR_GEN_ILLEGAL_INJECT_EN  when defined, every 16th word of a run is
//   replaced by an opcode-63 encoding and flagged on illegal.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start
// RUN   | offering words until emitted reaches length
// DONE  | one cycle, done pulse high, then back to IDLE

module instr_stream_gen #(
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             valid,
  input  logic             ready,
  output logic [31:0]      instr,
  output logic [5:0]       op_index,
  output logic             illegal,
  output logic [LEN_W-1:0] emitted,
  output logic             done
);

  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] emitted_inc;
  logic [5:0]       k_raw;
  logic [5:0]       k;
  logic [31:0]      word;
  logic             inject;

  function automatic logic [5:0] special_funct(input logic [5:0] idx);
    case (idx)
      6'd0:    return 6'h20; // add
      6'd1:    return 6'h21; // addu
      6'd2:    return 6'h24; // and
      6'd3:    return 6'h1A; // div
      6'd4:    return 6'h1B; // divu
      6'd5:    return 6'h09; // jalr
      6'd6:    return 6'h08; // jr
      6'd7:    return 6'h10; // mfhi
      6'd8:    return 6'h12; // mflo
      6'd9:    return 6'h11; // mthi
      6'd10:   return 6'h13; // mtlo
      6'd11:   return 6'h18; // mult
      6'd12:   return 6'h19; // multu
      6'd13:   return 6'h27; // nor
      6'd14:   return 6'h25; // or
      6'd15:   return 6'h00; // sll
      6'd16:   return 6'h04; // sllv
      6'd17:   return 6'h2A; // slt
      6'd18:   return 6'h2B; // sltu
      6'd19:   return 6'h03; // sra
      6'd20:   return 6'h07; // srav
      6'd21:   return 6'h02; // srl
      6'd22:   return 6'h06; // srlv
      6'd23:   return 6'h22; // sub
      6'd24:   return 6'h23; // subu
      6'd25:   return 6'h26; // xor
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] itype_opcode(input logic [5:0] idx);
    case (idx)
      6'd33:   return 6'b001000; // addi
      6'd34:   return 6'b001001; // addiu
      6'd35:   return 6'b001100; // andi
      6'd36:   return 6'b000100; // beq
      6'd37:   return 6'b000111; // bgtz
      6'd38:   return 6'b000110; // blez
      6'd39:   return 6'b000101; // bne
      6'd40:   return 6'b000010; // j
      6'd41:   return 6'b000011; // jal
      6'd42:   return 6'b100000; // lb
      6'd43:   return 6'b100100; // lbu
      6'd44:   return 6'b100001; // lh
      6'd45:   return 6'b100101; // lhu
      6'd46:   return 6'b001111; // lui
      6'd47:   return 6'b100011; // lw
      6'd48:   return 6'b001101; // ori
      6'd49:   return 6'b101000; // sb
      6'd50:   return 6'b101001; // sh
      6'd51:   return 6'b001010; // slti
      6'd52:   return 6'b001011; // sltiu
      6'd53:   return 6'b101011; // sw
      6'd54:   return 6'b001110; // xori
      default: return 6'b001000;
    endcase
  endfunction

  // Galois step, shift right, feedback from bit 0.
  assign lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  assign emitted_inc = emitted + {{(LEN_W-1){1'b0}}, 1'b1};

  // 64 raw values folded onto 55: values 55..63 alias onto 0..8.
  assign k_raw = lfsr[5:0];
  assign k     = (k_raw >= 6'd55) ? (k_raw - 6'd55) : k_raw;

  always_comb begin
    word = 32'h0;
    if (k <= 6'd25) begin
      // shamt only carries LFSR bits for the immediate shifts
      if (k == 6'd15 || k == 6'd19 || k == 6'd21)
        word = {6'b000000, lfsr[25:11], lfsr[10:6], special_funct(k)};
      else
        word = {6'b000000, lfsr[25:11], 5'b00000, special_funct(k)};
    end else if (k <= 6'd29) begin
      case (k)
        6'd26:   word = {6'b000001, lfsr[25:21], 5'b00001, lfsr[15:0]}; // bgez
        6'd27:   word = {6'b000001, lfsr[25:21], 5'b10001, lfsr[15:0]}; // bgezal
        6'd28:   word = {6'b000001, lfsr[25:21], 5'b00000, lfsr[15:0]}; // bltz
        default: word = {6'b000001, lfsr[25:21], 5'b10000, lfsr[15:0]}; // bltzal
      endcase
    end else if (k == 6'd30) begin
      word = {6'b010000, 5'b00000, lfsr[20:11], 11'h000};              // mfc0
    end else if (k == 6'd31) begin
      word = {6'b010000, 5'b00100, lfsr[20:11], 11'h000};              // mtc0
    end else if (k == 6'd32) begin
      word = 32'h4200_0018;                                            // eret
    end else begin
      word = {itype_opcode(k), lfsr[25:0]};
    end
  end

`ifdef INSTR_GEN_ILLEGAL_INJECT_EN
  // Every 16th word of a run (emitted = 15, 31, ...) is replaced.
  assign inject = valid && (emitted[3:0] == 4'hF);
`else
  assign inject = 1'b0;
`endif

  assign instr    = inject ? {6'b111111, lfsr[25:0]} : word;
  assign op_index = inject ? 6'd63 : k;
  assign illegal  = inject;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      lfsr    <= SEED_EFF;
      len_q   <= '0;
      emitted <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            lfsr    <= SEED_EFF;
            len_q   <= length;
            emitted <= '0;
            if (length != '0) begin
              state <= S_RUN;
              valid <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (valid && ready) begin
            lfsr    <= lfsr_next;
            emitted <= emitted_inc;
            if (emitted_inc == len_q) begin
              state <= S_DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_gen.sv
// Directed bench for instr_stream_gen: three instances (SEED 1, 0x36, 0x3F)
// share the stimulus; expected words are hand-computed, and a long random-ready
// run is checked with an independent decoder of the MIPS encodings.
module tb_instr_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [15:0] length;

  logic        valid_a, illegal_a, done_a;
  logic [31:0] instr_a;
  logic [5:0]  op_index_a;
  logic [15:0] emitted_a;

  logic        valid_b, illegal_b, done_b;
  logic [31:0] instr_b;
  logic [5:0]  op_index_b;
  logic [15:0] emitted_b;

  logic        valid_c, illegal_c, done_c;
  logic [31:0] instr_c;
  logic [5:0]  op_index_c;
  logic [15:0] emitted_c;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] SP_FUNCT [26] = '{
    6'h20, 6'h21, 6'h24, 6'h1A, 6'h1B, 6'h09, 6'h08, 6'h10, 6'h12, 6'h11,
    6'h13, 6'h18, 6'h19, 6'h27, 6'h25, 6'h00, 6'h04, 6'h2A, 6'h2B, 6'h03,
    6'h07, 6'h02, 6'h06, 6'h22, 6'h23, 6'h26};
  localparam logic [4:0] RG_CODE [4] = '{5'b00001, 5'b10001, 5'b00000, 5'b10000};
  localparam logic [5:0] IT_OP [22] = '{
    6'b001000, 6'b001001, 6'b001100, 6'b000100, 6'b000111, 6'b000110,
    6'b000101, 6'b000010, 6'b000011, 6'b100000, 6'b100100, 6'b100001,
    6'b100101, 6'b001111, 6'b100011, 6'b001101, 6'b101000, 6'b101001,
    6'b001010, 6'b001011, 6'b101011, 6'b001110};

  instr_stream_gen #(.SEED(32'h0000_0001), .LEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .valid(valid_a), .ready(ready), .instr(instr_a), .op_index(op_index_a),
    .illegal(illegal_a), .emitted(emitted_a), .done(done_a));

  instr_stream_gen #(.SEED(32'h0000_0036), .LEN_W(16)) u_dut36 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .valid(valid_b), .ready(ready), .instr(instr_b), .op_index(op_index_b),
    .illegal(illegal_b), .emitted(emitted_b), .done(done_b));

  instr_stream_gen #(.SEED(32'h0000_003F), .LEN_W(16)) u_dut3f (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .valid(valid_c), .ready(ready), .instr(instr_c), .op_index(op_index_c),
    .illegal(illegal_c), .emitted(emitted_c), .done(done_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Legality checker side: index 0..54 of a supported word, -1 otherwise.
  function automatic int decode_idx(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'b000000) begin
      for (int i = 0; i < 26; i++) begin
        if (w[5:0] == SP_FUNCT[i]) begin
          if (i != 15 && i != 19 && i != 21 && w[10:6] != 5'b0) return -1;
          return i;
        end
      end
      return -1;
    end
    if (op == 6'b000001) begin
      for (int i = 0; i < 4; i++)
        if (w[20:16] == RG_CODE[i]) return 26 + i;
      return -1;
    end
    if (op == 6'b010000) begin
      if (w == 32'h4200_0018) return 32;
      if (w[10:0] != 11'h0) return -1;
      if (w[25:21] == 5'b00000) return 30;
      if (w[25:21] == 5'b00100) return 31;
      return -1;
    end
    for (int i = 0; i < 22; i++)
      if (op == IT_OP[i]) return 33 + i;
    return -1;
  endfunction

  initial begin
    logic        finished;
    logic        prev_stall;
    logic        r;
    logic [31:0] prev_instr;
    logic        seen [64];
    int          words;
    int          nseen;

    reset  = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    length = 16'd0;
    tick;
    tick;
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_emitted", emitted_a, 16'd0);
    chk("rst_illegal", illegal_a, 1'b0);
    chk("rst_instr", instr_a, 32'h0000_0021);
    reset = 1'b0;
    tick;

    // single word from each seed
    length = 16'd1;
    ready  = 1'b1;
    start  = 1'b1;
    tick;
    start = 1'b0;
    chk("one_valid", valid_a, 1'b1);
    chk("one_instr", instr_a, 32'h0000_0021);
    chk("one_idx", op_index_a, 6'd1);
    chk("one_done_early", done_a, 1'b0);
    chk("s36_instr", instr_b, 32'h3800_0036);
    chk("s36_idx", op_index_b, 6'd54);
    chk("s3f_instr", instr_c, 32'h0000_0012);
    chk("s3f_idx", op_index_c, 6'd8);
    tick;
    chk("one_done", done_a, 1'b1);
    chk("one_valid_off", valid_a, 1'b0);
    chk("one_emitted", emitted_a, 16'd1);
    tick;
    chk("one_done_pulse", done_a, 1'b0);
    chk("one_emitted_hold", emitted_a, 16'd1);

    // four words with a three-cycle stall and a start during RUN
    length = 16'd4;
    ready  = 1'b0;
    start  = 1'b1;
    tick;
    chk("st_w1", instr_a, 32'h0000_0021);
    chk("st_valid1", valid_a, 1'b1);
    length = 16'd2;
    tick;
    start = 1'b0;
    chk("st_hold2", instr_a, 32'h0000_0021);
    chk("st_valid2", valid_a, 1'b1);
    chk("st_emit2", emitted_a, 16'd0);
    tick;
    chk("st_hold3", instr_a, 32'h0000_0021);
    chk("st_valid3", valid_a, 1'b1);
    ready = 1'b1;
    tick;
    chk("st_w2", instr_a, 32'h0020_001A);
    chk("st_w2_idx", op_index_a, 6'd3);
    chk("st_emit_w2", emitted_a, 16'd1);
    tick;
    chk("st_w3", instr_a, 32'h0030_0024);
    chk("st_w3_idx", op_index_a, 6'd2);
    chk("st_emit_w3", emitted_a, 16'd2);
    tick;
    chk("st_w4", instr_a, 32'h0018_0021);
    chk("st_w4_idx", op_index_a, 6'd1);
    chk("st_valid4", valid_a, 1'b1);
    tick;
    chk("st_done", done_a, 1'b1);
    chk("st_valid_off", valid_a, 1'b0);
    chk("st_emitted", emitted_a, 16'd4);
    tick;
    chk("st_done_pulse", done_a, 1'b0);
    chk("st_emit_hold", emitted_a, 16'd4);

    // zero length
    length = 16'd0;
    start  = 1'b1;
    tick;
    start = 1'b0;
    chk("z_done", done_a, 1'b1);
    chk("z_valid", valid_a, 1'b0);
    chk("z_emitted", emitted_a, 16'd0);
    tick;
    chk("z_done_pulse", done_a, 1'b0);
    chk("z_valid2", valid_a, 1'b0);

    // reset in the middle of a run
    length = 16'd5;
    ready  = 1'b1;
    start  = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("mr_emitted_pre", emitted_a, 16'd1);
    reset = 1'b1;
    tick;
    chk("mr_valid", valid_a, 1'b0);
    chk("mr_emitted", emitted_a, 16'd0);
    chk("mr_done", done_a, 1'b0);
    reset = 1'b0;
    tick;
    chk("mr_idle", valid_a, 1'b0);

    // long run with random ready
    foreach (seen[i]) seen[i] = 1'b0;
    words      = 0;
    finished   = 1'b0;
    prev_stall = 1'b0;
    prev_instr = 32'h0;
    length     = 16'd1000;
    ready      = 1'b0;
    start      = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      if (prev_stall) begin
        chk("rr_hold", instr_a, prev_instr);
        chk("rr_hold_valid", valid_a, 1'b1);
      end
      r     = ($urandom_range(0, 3) != 0);
      ready = r;
      if (valid_a && r) begin
        chk("rr_emitted", emitted_a, words);
`ifdef INSTR_GEN_ILLEGAL_INJECT_EN
        if ((words % 16) == 15) begin
          chk("rr_inj_op", instr_a[31:26], 6'h3F);
          chk("rr_inj_idx", op_index_a, 6'd63);
          chk("rr_inj_flag", illegal_a, 1'b1);
        end else begin
          chk("rr_decode", decode_idx(instr_a), op_index_a);
          chk("rr_illegal", illegal_a, 1'b0);
          seen[op_index_a] = 1'b1;
        end
`else
        chk("rr_decode", decode_idx(instr_a), op_index_a);
        chk("rr_illegal", illegal_a, 1'b0);
        seen[op_index_a] = 1'b1;
`endif
        words++;
      end
      prev_stall = valid_a && !r;
      prev_instr = instr_a;
      tick;
      if (done_a) finished = 1'b1;
    end
    chk("rr_finished", finished, 1'b1);
    chk("rr_words", words, 1000);
    chk("rr_emitted_final", emitted_a, 16'd1000);
    nseen = 0;
    for (int i = 0; i < 55; i++)
      if (seen[i]) nseen++;
    chk("rr_coverage", nseen, 55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_stream_gen.md
# instr_stream_gen

Self-checking instruction stream generator: emits a pseudo-random sequence of 32-bit MIPS instruction words, drawn uniformly-ish from the 55 instructions the core supports, over a valid/ready handshake. Used as the stimulus source for the fetch-side legality checker and for randomised pipeline soak tests: it is the encoder for that checker's decoder. It sits outside the core, driving the instruction memory model or the checker input directly.

## Interface
- `SEED`, 32'h0000_0001, initial LFSR state loaded on `start`; a value of 0 is replaced by 1.
- `LEN_W`, 16, width of `length` and `emitted`.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `length`  in  LEN_W  words to emit; sampled with `start`.
- `valid`  out  1  `instr` holds a word to transfer.
- `ready`  in  1  consumer accepts the word this cycle.
- `instr`  out  32  instruction word.
- `op_index`  out  6  index 0..54 of the emitted instruction.
- `illegal`  out  1  current word is a deliberately unsupported encoding.
- `emitted`  out  LEN_W  words transferred in the current run.
- `done`  out  1  one-cycle pulse when a run ends.

## Operation
- FSM: IDLE -> RUN on `start` with `length`!=0; IDLE -> DONE on `start` with `length`==0; RUN -> DONE on the transfer that makes `emitted`==`length`; DONE -> IDLE unconditionally.
- `start` outside IDLE is ignored; `length` is latched internally.
- Transfer = `valid & ready`. On a transfer: LFSR advances once, `emitted` increments.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, feedback from bit 0.
- Op index: k = lfsr[5:0]; if k>=55 then k-55.
- Index order: 0..25 SPECIAL add, addu, and, div, divu, jalr, jr, mfhi, mflo, mthi, mtlo, mult, multu, nor, or, sll, sllv, slt, sltu, sra, srav, srl, srlv, sub, subu, xor; 26..29 REGIMM bgez, bgezal, bltz, bltzal; 30..32 mfc0, mtc0, eret; 33..54 addi, addiu, andi, beq, bgtz, blez, bne, j, jal, lb, lbu, lh, lhu, lui, lw, ori, sb, sh, slti, sltiu, sw, xori.
- Field sourcing: rs=lfsr[25:21], rt=lfsr[20:16], rd=lfsr[15:11], imm=lfsr[15:0], target=lfsr[25:0]. SPECIAL: opcode 0, funct per instruction, shamt=lfsr[10:6] for sll/sra/srl, else 0. REGIMM: opcode 000001, rt forced to the instruction code, rs and imm from LFSR. mfc0/mtc0: opcode 010000, rs forced 00000/00100, rt and rd from LFSR, bits[10:0]=0. eret: exactly 32'h4200_0018. Others: fixed opcode, remaining fields from LFSR.
- `instr`, `op_index`, `illegal` are combinational functions of registered state only; no combinational path from `ready`/`start`.
- Reset (any state, any cycle): IDLE, `valid`=0, `done`=0, `emitted`=0, `illegal`=0, LFSR=SEED (0->1); `instr`/`op_index` reflect that LFSR but are don't-care while `valid`=0.

## Timing
- `start` accepted at cycle N -> `valid`=1 at N+1 with the word from SEED.
- `valid` stays high and `instr` stable until transfer; never withdrawn in RUN.
- Back-to-back: with `ready` held high, one word per cycle; next word visible the cycle after each transfer.
- Final transfer at cycle M -> `valid`=0 and `done`=1 at M+1, IDLE at M+2; `emitted` holds the final count until next `start`, which clears it.
- `length`==0: `done` pulses at N+1, `valid` never rises.
- `emitted` never exceeds `length`; no wrap within a run.

## Configuration
- `INSTR_GEN_ILLEGAL_INJECT_EN` defined: when `emitted[3:0]`==4'hF, the current word is replaced by {6'b111111, lfsr[25:0]}, `illegal`=1, `op_index`=63; the word counts toward `length` and advances the LFSR normally.
- Undefined: `illegal` tied 0, every word is a supported encoding.

## Test plan
- SEED=1, `length`=1, `ready`=1: `instr`=32'h0000_0021 (addu), `op_index`=1, `done` pulse two cycles after `start`, `emitted`=1.
- SEED=32'h36, `length`=1: `instr`=32'h3800_0036 (xori); SEED=32'h3F: k=63->8, `instr`=32'h0000_0012 (mflo).
- SEED=1, `length`=4, `ready` low 3 cycles after first `valid`: `instr` stable throughout stall, exactly 4 transfers, LFSR sequence matches model.
- `length`=0: `done` at N+1, `valid` never 1; `start` during RUN ignored; `reset` mid-run -> `valid`=0, `emitted`=0 next cycle.
- `length`=1000, random `ready`: every word decodes as supported by the legality checker, all 55 indices appear; with `INSTR_GEN_ILLEGAL_INJECT_EN`, words 16, 32, ... have `illegal`=1 and opcode 6'b111111, checker flags exactly those.
